instr_sequencer: RTL
====================

// Module: instr_sequencer
// PURPOSE
//   Upstream control stage for the 4-register add/mul datapath. Holds a small program
//   of 8-bit instructions, fetches them in order, drives the datapath instruction bus
//   and decoder enable, waits for the unstored result, and writes it back to a register.
//   Writeback goes through a one-hot load strobe plus a load-data bus that replace the
//   manual register switches.
// PARAMETERS
//   ADDR_W       3   program address width; program depth = 2**ADDR_W
//   EXEC_CYCLES  2   cycles decoding is held high before the result is sampled (1..15)
// PORTS
//   clock        in   1       single rising-edge clock
//   clear        in   1       synchronous, active-high reset
//   prog_we      in   1       program write strobe
//   prog_addr    in   ADDR_W  program write address
//   prog_data    in   8       program write data
//   start        in   1       level; sampled in IDLE/HALT to begin at pc=0
//   result       in   8       datapath output0 (mul when bit7=1, add when bit7=0)
//   instruction  out  8       registered instruction to datapath
//                             [7]=opcode, [3:2]=reg A, [1:0]=reg B
//   decoding     out  1       decoder enable for the register-to-bus drivers
//   reg_load     out  4       one-hot writeback strobe, bit0=r1 .. bit3=r4
//   load_data    out  8       writeback data, replaces the manual constant load
//   pc           out  ADDR_W  address of the current/next instruction
//   busy         out  1       high in FETCH/DECODE/EXEC/WB
//   halted       out  1       high in HALT
// BEHAVIOUR
//   Encoding: bit7 opcode (1=mul, 0=add); bit6 WB (write result to reg A);
//     bit5 HALT (stop after this instruction); bit4 reserved, ignored.
//   Reset (clear=1): state=IDLE. instruction, load_data, pc = 0. decoding, reg_load,
//     busy, halted = 0. Program memory is NOT cleared.
//   States:
//     IDLE:   start=1 -> FETCH, with pc=0.
//     FETCH:  instruction <= mem[pc] -> DECODE.
//     DECODE: decoding=1; exec counter=0 -> EXEC.
//     EXEC:   decoding=1. Counter increments each cycle. On the cycle the counter
//             equals EXEC_CYCLES-1: load_data <= result -> WB.
//     WB:     decoding=0. If bit6, reg_load[instruction[3:2]]=1 for exactly this
//             cycle, with load_data stable. pc <= pc+1 mod 2**ADDR_W (wraps to 0).
//             Next: HALT if bit5, else FETCH.
//     HALT:   halted=1; instruction and pc hold. start=1 -> FETCH, with pc=0.
//   Latency: EXEC_CYCLES+3 cycles per instruction, from entering FETCH to leaving WB.
//   reg_load is never multi-hot. It is zero outside WB.
//   prog_we is honoured only when busy=0. Writes while busy are dropped.
//   Same-cycle write and start from IDLE: the write commits and the fetch sees the
//     new data.
//   start while busy is ignored. Program execution is not restarted.
//   clear mid-instruction aborts immediately. No reg_load pulse is issued for the
//     aborted instruction.
//   Register A == register B is legal. The datapath handles it; no special case here.
// TESTING
//   1. Reset: hold clear 2 cycles -> every output 0, state IDLE. Memory written
//      earlier is still readable after a new start.
//   2. Add+WB: mem[0]=0x41 (add r1,r2, WB to r1, no halt), result=0x05, start ->
//      decoding high 3 cycles; reg_load=4'b0001 and load_data=0x05 in WB; pc=1.
//   3. Mul+halt: mem[0]=0xEE (mul r4,r3, WB r4, halt), result=0x0C -> reg_load=4'b1000
//      and load_data=0x0C in WB; halted=1; pc=1. start again -> restarts at pc=0.
//   4. No-WB: mem[0]=0x06, mem[1]=0x25 -> reg_load stays 0 for both instructions;
//      halt after pc=1 -> halted=1, pc=2.
//   5. Wrap: all 8 words 0x40 (no halt) -> pc counts 0..7 then 0. busy stays high.
//      One reg_load pulse every 5 cycles.
//   6. Abuse: prog_we to mem[3]=0xFF while busy -> mem[3] unchanged. clear asserted
//      in EXEC -> no reg_load pulse, all outputs 0 next cycle.

Source files
------------

// File: rtl/instr_sequencer.sv
// Program sequencer for the 4-register add/mul datapath: fetch, decode, exec, writeback.
// Latency: EXEC_CYCLES+3 cycles per instruction from FETCH entry to WB exit.
// Backpressure: none; start while busy is ignored and program writes while busy are dropped.
module instr_sequencer #(
  parameter int ADDR_W      = 3,
  parameter int EXEC_CYCLES = 2
) (
  input  logic              clock,
  input  logic              clear,
  input  logic              prog_we,
  input  logic [ADDR_W-1:0] prog_addr,
  input  logic [7:0]        prog_data,
  input  logic              start,
  input  logic [7:0]        result,
  output logic [7:0]        instruction,
  output logic              decoding,
  output logic [3:0]        reg_load,
  output logic [7:0]        load_data,
  output logic [ADDR_W-1:0] pc,
  output logic              busy,
  output logic              halted
);

  localparam int         DEPTH     = 1 << ADDR_W;
  localparam logic [3:0] EXEC_LAST = 4'(EXEC_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_WB,
    S_HALT
  } state_t;

  state_t            state_q, state_d;
  logic [3:0]        exec_cnt_q, exec_cnt_d;
  logic [7:0]        instr_d;
  logic [7:0]        load_data_d;
  logic [ADDR_W-1:0] pc_d;
  logic [7:0]        mem [DEPTH];

  // Program store is deliberately left out of clear so a program survives a reset.
  always_ff @(posedge clock) begin
    if (prog_we && !busy) begin
      mem[prog_addr] <= prog_data;
    end
  end

  always_ff @(posedge clock) begin
    if (clear) begin
      state_q     <= S_IDLE;
      exec_cnt_q  <= '0;
      instruction <= '0;
      load_data   <= '0;
      pc          <= '0;
    end else begin
      state_q     <= state_d;
      exec_cnt_q  <= exec_cnt_d;
      instruction <= instr_d;
      load_data   <= load_data_d;
      pc          <= pc_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    exec_cnt_d  = exec_cnt_q;
    instr_d     = instruction;
    load_data_d = load_data;
    pc_d        = pc;
    decoding    = 1'b0;
    reg_load    = 4'b0000;
    busy        = 1'b0;
    halted      = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          pc_d    = '0;
          state_d = S_FETCH;
        end
      end

      S_FETCH: begin
        busy    = 1'b1;
        instr_d = mem[pc];
        state_d = S_DECODE;
      end

      S_DECODE: begin
        busy       = 1'b1;
        decoding   = 1'b1;
        exec_cnt_d = '0;
        state_d    = S_EXEC;
      end

      // The result is only trusted on the last held cycle of decoding.
      S_EXEC: begin
        busy       = 1'b1;
        decoding   = 1'b1;
        exec_cnt_d = exec_cnt_q + 4'd1;
        if (exec_cnt_q == EXEC_LAST) begin
          load_data_d = result;
          state_d     = S_WB;
        end
      end

      S_WB: begin
        busy = 1'b1;
        if (instruction[6]) begin
          reg_load[instruction[3:2]] = 1'b1;
        end
        pc_d    = pc + ADDR_W'(1);
        state_d = instruction[5] ? S_HALT : S_FETCH;
      end

      S_HALT: begin
        halted = 1'b1;
        if (start) begin
          pc_d    = '0;
          state_d = S_FETCH;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

endmodule
